fp_add_issue: RTL and testbench

Operand issue and special-case stage placed directly upstream of the FP adder datapath. It accepts add requests through a valid/ready handshake and buffers them in a small FIFO. It drives one request per cycle into the combinational adder. Operands the adder cannot handle (NaN, Inf, zero, and optionally subnormal) are classified and resolved locally. The adder result and the bypass result are merged into a registered, back-pressurable output with the request tag.

---
 rtl/fp_add_issue.sv | 174 +++++++++++++++++
 tb/tb_fp_add_issue.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_issue.sv
// Operand issue and special-case stage ahead of the FP adder: input FIFO -> issue reg -> output reg.
// Optional macro FP_ADD_ISSUE_DAZ_EN flushes FP32 subnormal operands to signed zero.
module fp_add_issue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_fmt,
    input  logic [31:0]      in_x,
    input  logic [31:0]      in_y,
    input  logic [TAG_W-1:0] in_tag,
    output logic             add_fmt,
    output logic [31:0]      add_x,
    output logic [31:0]      add_y,
    input  logic [31:0]      add_r,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_r,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_fmt,
    output logic             out_byp,
    output logic             out_nv
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PtrW:0] Full = (PtrW + 1)'(DEPTH);
    localparam logic FmtFp32 = 1'b0;
    localparam logic [31:0] QNaN = 32'h7FC00000;

    typedef struct packed {
        logic             fmt;
        logic [TAG_W-1:0] tag;
        logic [31:0]      x;
        logic [31:0]      y;
    } req_t;

    req_t            fifoMem [DEPTH];
    logic [PtrW-1:0] wrPtr, rdPtr;
    logic [PtrW:0]   count, countNext;
    logic            push, pop;

    req_t  s1Req;
    logic  s1Valid, s1Load, s1Adv;

    logic [31:0] xC, yC, bypR;
    logic        xNan, yNan, xInf, yInf, xZero, yZero, byp, nv;

    // FIFO
    assign in_ready = (count != Full);
    assign push     = in_valid && in_ready;
    assign s1Adv    = s1Valid && (!out_valid || out_ready);
    assign s1Load   = (!s1Valid || s1Adv) && (count != '0);
    assign pop      = s1Load;

    always_comb begin
        countNext = count;
        unique case ({push, pop})
            2'b10:   countNext = count + 1'b1;
            2'b01:   countNext = count - 1'b1;
            default: countNext = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            count <= countNext;
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifoMem[wrPtr] <= '{fmt: in_fmt, tag: in_tag, x: in_x, y: in_y};
    end

    // S1 issue register
    always_ff @(posedge clk) begin
        if (rst) begin
            s1Valid <= 1'b0;
            s1Req   <= '0;
        end else if (s1Load) begin
            s1Valid <= 1'b1;
            s1Req   <= fifoMem[rdPtr];
        end else if (s1Adv) begin
            s1Valid <= 1'b0;
        end
    end

    assign add_x   = s1Valid ? s1Req.x : 32'h0;
    assign add_y   = s1Valid ? s1Req.y : 32'h0;
    assign add_fmt = s1Valid ? s1Req.fmt : 1'b0;

    always_comb begin
        xC = s1Req.x;
        yC = s1Req.y;
`ifdef FP_ADD_ISSUE_DAZ_EN
        if (s1Req.x[30:23] == 8'h00 && s1Req.x[22:0] != 23'h0) xC = {s1Req.x[31], 31'h0};
        if (s1Req.y[30:23] == 8'h00 && s1Req.y[22:0] != 23'h0) yC = {s1Req.y[31], 31'h0};
`endif
    end

    assign xNan  = (&xC[30:23]) && (|xC[22:0]);
    assign yNan  = (&yC[30:23]) && (|yC[22:0]);
    assign xInf  = (&xC[30:23]) && !(|xC[22:0]);
    assign yInf  = (&yC[30:23]) && !(|yC[22:0]);
    assign xZero = (xC[30:0] == 31'h0);
    assign yZero = (yC[30:0] == 31'h0);

    // Priority NaN > Inf > zero > adder; FP16 always goes to the adder.
    always_comb begin
        bypR = 32'h0;
        byp  = 1'b0;
        nv   = 1'b0;
        if (s1Req.fmt == FmtFp32) begin
            if (xNan || yNan) begin
                byp  = 1'b1;
                bypR = QNaN;
                nv   = (xNan && !xC[22]) || (yNan && !yC[22]);
            end else if (xInf && yInf) begin
                byp = 1'b1;
                if (xC[31] != yC[31]) begin
                    bypR = QNaN;
                    nv   = 1'b1;
                end else begin
                    bypR = xC;
                end
            end else if (xInf) begin
                byp  = 1'b1;
                bypR = xC;
            end else if (yInf) begin
                byp  = 1'b1;
                bypR = yC;
            end else if (xZero && yZero) begin
                byp  = 1'b1;
                bypR = {xC[31] && yC[31], 31'h0};
            end else if (xZero) begin
                byp  = 1'b1;
                bypR = yC;
            end else if (yZero) begin
                byp  = 1'b1;
                bypR = xC;
            end
        end
    end

    // S2 output register; fields only change on a new transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_r     <= 32'h0;
            out_tag   <= '0;
            out_fmt   <= 1'b0;
            out_byp   <= 1'b0;
            out_nv    <= 1'b0;
        end else if (s1Adv) begin
            out_valid <= 1'b1;
            out_r     <= byp ? bypR : add_r;
            out_tag   <= s1Req.tag;
            out_fmt   <= s1Req.fmt;
            out_byp   <= byp;
            out_nv    <= nv;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fp_add_issue.sv
// Scoreboard bench for fp_add_issue: directed vectors, back-pressure, reset flush, DAZ.
// The environment adder is a stand-in: exact for 1.0+2.0, integer sum otherwise.
module tb_fp_add_issue;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready, in_fmt;
    logic [31:0]      in_x, in_y;
    logic [TAG_W-1:0] in_tag;
    logic             add_fmt;
    logic [31:0]      add_x, add_y, add_r;
    logic             out_valid, out_ready;
    logic [31:0]      out_r;
    logic [TAG_W-1:0] out_tag;
    logic             out_fmt, out_byp, out_nv;

    typedef struct packed {
        logic [31:0]      r;
        logic [TAG_W-1:0] tag;
        logic             fmt;
        logic             byp;
        logic             nv;
    } exp_t;

    exp_t sbq[$];
    exp_t monExp;
    int   nChecks = 0;
    int   nErr = 0;

    fp_add_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
        .in_x(in_x), .in_y(in_y), .in_tag(in_tag),
        .add_fmt(add_fmt), .add_x(add_x), .add_y(add_y), .add_r(add_r),
        .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r),
        .out_tag(out_tag), .out_fmt(out_fmt), .out_byp(out_byp), .out_nv(out_nv)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fakeAdd(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        return a + b;
    endfunction

    assign add_r = fakeAdd(add_x, add_y);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nChecks++;
        if (act !== req) begin
            nErr++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    // Offers one request (starting just after a rising edge) until accepted or timed out.
    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic fmt,
                        input logic [TAG_W-1:0] tag, input logic [31:0] r, input logic byp,
                        input logic nv, input bit track);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_x = x;
        in_y = y;
        in_fmt = fmt;
        in_tag = tag;
        for (int i = 0; i < 100 && !ok; i++) begin
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        else if (track) sbq.push_back('{r: r, tag: tag, fmt: fmt, byp: byp, nv: nv});
    endtask

    // Monitor: every output handshake pops one expected response.
    initial forever begin
        @(negedge clk);
        if (!rst && out_valid && out_ready) begin
            nChecks++;
            if (sbq.size() == 0) begin
                nErr++;
                $display("FAIL unexpected_output: got tag %0d r %h, want no output", out_tag,
                         out_r);
            end else begin
                monExp = sbq.pop_front();
                if ({out_r, out_tag, out_fmt, out_byp, out_nv} !== monExp) begin
                    nErr++;
                    $display("FAIL out_tag%0d: got r=%h tag=%0d fmt=%b byp=%b nv=%b, want r=%h tag=%0d fmt=%b byp=%b nv=%b",
                             monExp.tag, out_r, out_tag, out_fmt, out_byp, out_nv,
                             monExp.r, monExp.tag, monExp.fmt, monExp.byp, monExp.nv);
                end
            end
        end
    end

    initial begin
        int acc;
        int run;
        bit ok;
        rst = 1'b1;
        in_valid = 1'b0;
        in_fmt = 1'b0;
        in_x = '0;
        in_y = '0;
        in_tag = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_flags", {26'h0, in_ready, out_valid, out_fmt, out_byp, out_nv, add_fmt},
              32'h20);
        check("rst_out_r", out_r, 32'h0);
        check("rst_out_tag", 32'(out_tag), 32'h0);
        check("rst_add_xy", add_x | add_y, 32'h0);
        rst = 1'b0;
        out_ready = 1'b1;

        // Latency: accept at E0, S1 at E1, out_valid after E2
        send(32'h3F800000, 32'h40000000, 1'b0, 4'd3, 32'h40400000, 1'b0, 1'b0, 1'b1);
        check("lat_e0_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("lat_e1_add_x", add_x, 32'h3F800000);
        check("lat_e1_add_y", add_y, 32'h40000000);
        check("lat_e1_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("lat_e2_valid", 32'(out_valid), 32'd1);

        // Directed special cases, streamed back to back
        send(32'h7F800000, 32'hFF800000, 1'b0, 4'd1, 32'h7FC00000, 1'b1, 1'b1, 1'b1);
        send(32'h7F800001, 32'h3F800000, 1'b0, 4'd2, 32'h7FC00000, 1'b1, 1'b1, 1'b1);
        send(32'h7FC00001, 32'h3F800000, 1'b0, 4'd4, 32'h7FC00000, 1'b1, 1'b0, 1'b1);
        send(32'h00000000, 32'hC0A00000, 1'b0, 4'd5, 32'hC0A00000, 1'b1, 1'b0, 1'b1);
        send(32'h80000000, 32'h80000000, 1'b0, 4'd6, 32'h80000000, 1'b1, 1'b0, 1'b1);
        send(32'h80000000, 32'h00000000, 1'b0, 4'd7, 32'h00000000, 1'b1, 1'b0, 1'b1);
        send(32'h7F800000, 32'h3F800000, 1'b0, 4'd8, 32'h7F800000, 1'b1, 1'b0, 1'b1);
        send(32'hFF800000, 32'hFF800000, 1'b0, 4'd9, 32'hFF800000, 1'b1, 1'b0, 1'b1);
        send(32'h40A00000, 32'h80000000, 1'b0, 4'd10, 32'h40A00000, 1'b1, 1'b0, 1'b1);
        send(32'h7F800000, 32'hFF800000, 1'b1, 4'd11, fakeAdd(32'h7F800000, 32'hFF800000),
             1'b0, 1'b0, 1'b1);
`ifdef FP_ADD_ISSUE_DAZ_EN
        send(32'h00000001, 32'h3F800000, 1'b0, 4'd12, 32'h3F800000, 1'b1, 1'b0, 1'b1);
`else
        send(32'h00000001, 32'h3F800000, 1'b0, 4'd12, fakeAdd(32'h00000001, 32'h3F800000),
             1'b0, 1'b0, 1'b1);
`endif
        for (int i = 0; i < 50 && sbq.size() != 0; i++) @(posedge clk);
        #1;
        check("stream_drained", 32'(sbq.size()), 32'd0);

        // Back-pressure: capacity DEPTH+2, then in-order drain with no bubbles
        out_ready = 1'b0;
        acc = 0;
        for (int t = 0; t < 8; t++) begin
            in_valid = 1'b1;
            in_x = 32'h3F800000;
            in_y = 32'h40000000;
            in_fmt = 1'b0;
            in_tag = TAG_W'(t);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) begin
                acc++;
                sbq.push_back('{r: 32'h40400000, tag: TAG_W'(t), fmt: 1'b0, byp: 1'b0,
                                nv: 1'b0});
            end
        end
        in_valid = 1'b0;
        check("bp_accepted", 32'(acc), 32'd6);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        run = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) run++;
            @(posedge clk);
            #1;
        end
        check("bp_consecutive", 32'(run), 32'd6);
        check("bp_after_valid", 32'(out_valid), 32'd0);
        check("bp_drained", 32'(sbq.size()), 32'd0);

        // Reset mid-flight: these three must never emerge
        out_ready = 1'b0;
        send(32'h3F800000, 32'h40000000, 1'b0, 4'd13, 32'h0, 1'b0, 1'b0, 1'b0);
        send(32'h3F800000, 32'h40000000, 1'b0, 4'd14, 32'h0, 1'b0, 1'b0, 1'b0);
        send(32'h3F800000, 32'h40000000, 1'b0, 4'd15, 32'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rstmid_out_valid", 32'(out_valid), 32'd0);
        check("rstmid_in_ready", 32'(in_ready), 32'd1);
        check("rstmid_add_x", add_x, 32'h0);
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("rstmid_no_output", 32'(out_valid), 32'd0);
        check("final_sb_empty", 32'(sbq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErr);
        $finish;
    end

endmodule
